// File: rtl/out_bus_pkg.sv
// Shared types and defaults for the output bus sequencer.
// FSM encoding, transfer record, timing and depth constants.
package out_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } xfer_t;

  localparam int DEF_DEPTH    = 4;
  localparam int DEF_T_SETUP  = 1;
  localparam int DEF_T_STROBE = 2;
  localparam int DEF_T_HOLD   = 1;
  localparam int TW           = 8;

endpackage

// File: rtl/out_fifo.sv
// Synchronous FIFO holding queued bus transfers.
// Pointers wrap modulo DEPTH; push when full and pop when empty are ignored.
module out_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           wdata,
  output logic [W-1:0]           rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = count == CW'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/out_bus_sequencer.sv
// Drains queued address/data transfers onto a latch bus with
// programmable setup, strobe and hold timing on LE.
module out_bus_sequencer
  import out_bus_pkg::*;
#(
  parameter int DEPTH    = DEF_DEPTH,
  parameter int T_SETUP  = DEF_T_SETUP,
  parameter int T_STROBE = DEF_T_STROBE,
  parameter int T_HOLD   = DEF_T_HOLD
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic                   wr_en,
  input  logic [7:0]             wr_addr,
  input  logic [7:0]             wr_data,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  output logic                   busy,
  output logic                   ovf,
  output logic [7:0]             Addres_Data_Bus,
  output logic [7:0]             DataOut_Bus,
  output logic                   LE
);

  state_t        state;
  state_t        state_n;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_n;
  logic          le_n;
  logic          pop;
  logic          empty;
  xfer_t         head;

  out_fifo #(
    .DEPTH(DEPTH),
    .W    ($bits(xfer_t))
  ) u_fifo (
    .clk  (Clk),
    .rst  (Rst),
    .push (wr_en),
    .pop  (pop),
    .wdata({wr_addr, wr_data}),
    .rdata(head),
    .count(count),
    .full (full),
    .empty(empty)
  );

  assign busy = state != IDLE;

  always_comb begin
    state_n = state;
    timer_n = timer;
    le_n    = LE;
    pop     = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_n = SETUP;
          timer_n = TW'(T_SETUP);
        end
      end
      SETUP: begin
        if (timer == TW'(1)) begin
          state_n = STROBE;
          timer_n = TW'(T_STROBE);
          le_n    = 1'b1;
        end else begin
          timer_n = timer - TW'(1);
        end
      end
      STROBE: begin
        if (timer == TW'(1)) begin
          state_n = HOLD;
          timer_n = TW'(T_HOLD);
          le_n    = 1'b0;
        end else begin
          timer_n = timer - TW'(1);
        end
      end
      HOLD: begin
        // back-to-back: next transfer starts without an IDLE cycle
        if (timer == TW'(1)) begin
          if (!empty) begin
            pop     = 1'b1;
            state_n = SETUP;
            timer_n = TW'(T_SETUP);
          end else begin
            state_n = IDLE;
            timer_n = '0;
          end
        end else begin
          timer_n = timer - TW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state           <= IDLE;
      timer           <= '0;
      LE              <= 1'b0;
      Addres_Data_Bus <= '0;
      DataOut_Bus     <= '0;
      ovf             <= 1'b0;
    end else begin
      state <= state_n;
      timer <= timer_n;
      LE    <= le_n;
      if (pop) begin
        Addres_Data_Bus <= head.addr;
        DataOut_Bus     <= head.data;
      end
      if (wr_en && full) ovf <= 1'b1;
    end
  end

endmodule
